bundle_window_ctrl: RTL and testbench

BUNDLE_WINDOW_CTRL -- requirements
Module: bundle_window_ctrl

---
 rtl/hdc_ctrl_pkg.sv | 12 +
 rtl/bundle_window_ctrl.sv | 104 ++++++++++
 tb/tb_bundle_window_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdc_ctrl_pkg.sv
// Shared types for the HDC datapath controllers.
// Holds the window-controller FSM state encoding.
package hdc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIN   = 2'd2,
        STALL = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/bundle_window_ctrl.sv
// Windowed bundler controller: counts hypervectors per window,
// strobes the bundler finish and hands off the bundled result.
module bundle_window_ctrl
    import hdc_ctrl_pkg::*;
#(
    parameter int COUNT_SIZE = 8,
    parameter int WCNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [COUNT_SIZE-1:0] cfg_win_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  bnd_en,
    output logic                  bnd_finish,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [WCNT_W-1:0]     win_count,
    output logic                  err_cfg
);

    ctrl_state_t           state;
    logic [COUNT_SIZE-1:0] cnt;
    logic [COUNT_SIZE-1:0] win_len;
    logic [COUNT_SIZE-1:0] cnt_inc;
    logic                  stop_pend;
    logic                  xfer;
    logic                  blocked;

    assign in_ready   = (state == ACCUM);
    assign bnd_en     = in_valid & in_ready;
    assign bnd_finish = (state == FIN);
    assign busy       = (state != IDLE);
    assign xfer       = bnd_en;
    assign cnt_inc    = cnt + 1'b1;
    // A result still waiting downstream must not be overwritten by FIN.
    assign blocked    = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            win_len   <= '0;
            stop_pend <= 1'b0;
            out_valid <= 1'b0;
            win_count <= '0;
            err_cfg   <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!stop && start) begin
                        if (cfg_win_len == '0) begin
                            err_cfg <= 1'b1;
                        end else begin
                            win_len <= cfg_win_len;
                            cnt     <= '0;
                            state   <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer)
                        cnt <= cnt_inc;
                    if (xfer && cnt_inc == win_len) begin
                        state <= blocked ? STALL : FIN;
                        if (stop)
                            stop_pend <= 1'b1;
                    end else if (stop) begin
                        if (xfer || cnt != '0) begin
                            stop_pend <= 1'b1;
                            state     <= blocked ? STALL : FIN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                STALL: begin
                    if (stop && cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        if (stop)
                            stop_pend <= 1'b1;
                        if (!blocked)
                            state <= FIN;
                    end
                end
                FIN: begin
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    win_count <= win_count + 1'b1;
                    stop_pend <= 1'b0;
                    state     <= (stop_pend || stop) ? IDLE : ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bundle_window_ctrl.sv
// Directed self-checking bench for bundle_window_ctrl.
// Table-driven vectors plus hand sequences for corner cases.
module tb_bundle_window_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start, stop;
    logic [7:0]  cfg_win_len;
    logic        in_valid, in_ready;
    logic        bnd_en, bnd_finish;
    logic        out_valid, out_ready;
    logic        busy;
    logic [15:0] win_count;
    logic        err_cfg;

    int passed = 0;
    int total  = 0;
    int fin_cnt = 0;
    int fin_base;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bnd_finish) fin_cnt++;

    bundle_window_ctrl #(.COUNT_SIZE(8), .WCNT_W(16)) dut (
        .clk(clk), .nrst(nrst),
        .start(start), .stop(stop),
        .cfg_win_len(cfg_win_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .bnd_en(bnd_en), .bnd_finish(bnd_finish),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .win_count(win_count),
        .err_cfg(err_cfg)
    );

    typedef struct {
        logic        st, sp, iv, ordy;
        logic [7:0]  len;
        logic        busy, ir, en, fin, ov;
        logic [15:0] wc;
    } vec_t;

    vec_t tv[11];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        start = 0; stop = 0; in_valid = 0;
        out_ready = 1; cfg_win_len = 8'd0;
        tick();
        tick();
        nrst = 1'b1;
        fin_base = fin_cnt;
    endtask

    function automatic vec_t mk(logic st, logic iv,
        logic b, logic ir, logic en, logic fin, logic ov, int wc);
        vec_t v;
        v.st = st; v.sp = 0; v.iv = iv; v.ordy = 1; v.len = 8'd3;
        v.busy = b; v.ir = ir; v.en = en; v.fin = fin; v.ov = ov;
        v.wc = 16'(wc);
        return v;
    endfunction

    initial begin
        tv[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 1, 1, 1, 0, 0, 0);
        tv[2]  = mk(0, 1, 1, 1, 1, 0, 0, 0);
        tv[3]  = mk(0, 1, 1, 1, 1, 0, 0, 0);
        tv[4]  = mk(0, 1, 1, 0, 0, 1, 0, 0);
        tv[5]  = mk(0, 1, 1, 1, 1, 0, 1, 1);
        tv[6]  = mk(0, 1, 1, 1, 1, 0, 0, 1);
        tv[7]  = mk(0, 1, 1, 1, 1, 0, 0, 1);
        tv[8]  = mk(0, 1, 1, 0, 0, 1, 0, 1);
        tv[9]  = mk(0, 1, 1, 1, 1, 0, 1, 2);
        tv[10] = mk(0, 0, 1, 1, 0, 0, 0, 2);

        // reset state
        nrst = 1'b0;
        start = 0; stop = 0; in_valid = 0;
        out_ready = 1; cfg_win_len = 8'd0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_wc", win_count, 0);
        chk("rst_err", err_cfg, 0);
        do_reset();

        // window of 3, 7 back-to-back inputs
        for (int i = 0; i < 11; i++) begin
            start = tv[i].st; stop = tv[i].sp;
            in_valid = tv[i].iv; out_ready = tv[i].ordy;
            cfg_win_len = tv[i].len;
            #1;
            chk($sformatf("w3[%0d].busy", i), busy, tv[i].busy);
            chk($sformatf("w3[%0d].ir", i), in_ready, tv[i].ir);
            chk($sformatf("w3[%0d].en", i), bnd_en, tv[i].en);
            chk($sformatf("w3[%0d].fin", i), bnd_finish, tv[i].fin);
            chk($sformatf("w3[%0d].ov", i), out_valid, tv[i].ov);
            chk($sformatf("w3[%0d].wc", i), win_count, tv[i].wc);
            tick();
        end
        chk("w3_fin_cnt", fin_cnt - fin_base, 2);
        in_valid = 1;
        tick();
        chk("w3_held_no_fin", bnd_finish, 0);
        tick();
        chk("w3_held_fin", bnd_finish, 1);

        // window of 4 with stalled output
        do_reset();
        cfg_win_len = 8'd4; start = 1;
        tick();
        start = 0; in_valid = 1;
        repeat (4) tick();
        chk("st_fin1", bnd_finish, 1);
        out_ready = 0;
        tick();
        chk("st_ov1", out_valid, 1);
        repeat (4) tick();
        in_valid = 0;
        #1;
        chk("st_busy", busy, 1);
        chk("st_ir", in_ready, 0);
        chk("st_fin0", bnd_finish, 0);
        tick();
        chk("st_hold_ir", in_ready, 0);
        chk("st_hold_ov", out_valid, 1);
        out_ready = 1;
        tick();
        chk("st_fin2", bnd_finish, 1);
        chk("st_ov_clr", out_valid, 0);
        tick();
        chk("st_ov2", out_valid, 1);
        chk("st_wc2", win_count, 2);
        chk("st_ir_back", in_ready, 1);

        // stop flushes a partial window
        do_reset();
        cfg_win_len = 8'd5; start = 1;
        tick();
        start = 0; in_valid = 1;
        repeat (2) tick();
        in_valid = 0; stop = 1;
        tick();
        stop = 0;
        chk("sp_fin", bnd_finish, 1);
        tick();
        chk("sp_busy", busy, 0);
        chk("sp_ov", out_valid, 1);
        chk("sp_wc", win_count, 1);
        chk("sp_fin_cnt", fin_cnt - fin_base, 1);
        tick();
        chk("sp_ov_clr", out_valid, 0);

        // zero-length config and start/stop collision
        do_reset();
        cfg_win_len = 8'd0; start = 1;
        tick();
        start = 0;
        chk("z_err", err_cfg, 1);
        chk("z_busy", busy, 0);
        cfg_win_len = 8'd3; start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("ss_busy", busy, 0);
        chk("ss_err_sticky", err_cfg, 1);

        // reset mid-window
        do_reset();
        cfg_win_len = 8'd4; start = 1;
        tick();
        start = 0; in_valid = 1;
        repeat (2) tick();
        chk("mr_busy_pre", busy, 1);
        nrst = 0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_ir", in_ready, 0);
        chk("mr_en", bnd_en, 0);
        chk("mr_fin", bnd_finish, 0);
        chk("mr_ov", out_valid, 0);
        chk("mr_wc", win_count, 0);
        tick();
        chk("mr_no_pulse", fin_cnt - fin_base, 0);
        nrst = 1; in_valid = 0;
        tick();
        chk("mr_idle", busy, 0);

        // maximal window length
        do_reset();
        cfg_win_len = 8'd255; start = 1;
        tick();
        start = 0; in_valid = 1;
        repeat (254) tick();
        chk("max_no_early", fin_cnt - fin_base, 0);
        chk("max_ir_254", in_ready, 1);
        tick();
        in_valid = 0;
        chk("max_fin", bnd_finish, 1);
        tick();
        chk("max_wc", win_count, 1);
        chk("max_ov", out_valid, 1);
        chk("max_ir", in_ready, 1);
        chk("max_fin_cnt", fin_cnt - fin_base, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
